// File: rtl/mist1032sa_uart_pkg.sv
// Shared definitions for the mist1032sa UART blocks.
// Holds the transmitter FSM encoding and the frame and baud-counter
// dimensions. The transmitter and baud generator import it, and a future
// receiver can import it too.
package mist1032sa_uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'h0,
      TX_START = 2'h1,
      TX_DATA  = 2'h2,
      TX_STOP  = 2'h3
   } tx_state_e;

   localparam int TICKS_PER_BIT = 4;
   localparam int DATA_BITS     = 8;
   localparam int BAUD_CNT_W    = 20;

endpackage

// File: rtl/mist1032sa_uart_baudgen.sv
// x4 baud tick generator. It produces a one-cycle clock enable, not a clock.
// Ports:
//   iCLOCK         system clock
//   inRESET        asynchronous active-low reset
//   iEXTBAUD_COUNT runtime tick limit, used when BAUDRATE_FIXED = 0
//   oTICK          registered one-cycle pulse every (limit + 1) clocks
module mist1032sa_uart_baudgen
   import mist1032sa_uart_pkg::*;
#(
   parameter bit                    BAUDRATE_FIXED   = 1'b1,
   parameter logic [BAUD_CNT_W-1:0] BAUDRATE_COUNTER = 20'd108
)(
   input  logic                  iCLOCK,
   input  logic                  inRESET,
   input  logic [BAUD_CNT_W-1:0] iEXTBAUD_COUNT,
   output logic                  oTICK
);

   logic [BAUD_CNT_W-1:0] limit;
   logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
   logic                  tick_q, tick_d;

   // The compare is >= rather than ==. If a smaller limit is written while
   // the counter is already above it, the next cycle produces a tick instead
   // of the counter running through a full wrap first.
   always_comb begin
      limit = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
      if (cnt_q >= limit) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + BAUD_CNT_W'(1);
         tick_d = 1'b0;
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign oTICK = tick_q;

endmodule

// File: rtl/mist1032sa_uart_transmitter.sv
// Byte-wide 8N1 UART transmitter that sends LSB first.
// A one-entry holding register sits in front of the shifter, so frames can
// run back to back with no idle gap.
// Ports:
//   iCLOCK, inRESET  clock and asynchronous active-low reset
//   iEXTBAUD_COUNT   runtime baud tick limit, used when BAUDRATE_FIXED = 0
//   iTX_REQ/iTX_DATA write strobe and byte; accepted only while oTX_FULL = 0
//   oTX_FULL         holding register occupied
//   oTX_BUSY         holding register occupied or shifter active
//   oUART_TXD        registered serial line, idle high
module mist1032sa_uart_transmitter
   import mist1032sa_uart_pkg::*;
#(
   parameter bit                    BAUDRATE_FIXED   = 1'b1,
   parameter logic [BAUD_CNT_W-1:0] BAUDRATE_COUNTER = 20'd108
)(
   input  logic                  iCLOCK,
   input  logic                  inRESET,
   input  logic [BAUD_CNT_W-1:0] iEXTBAUD_COUNT,
   input  logic                  iTX_REQ,
   input  logic [DATA_BITS-1:0]  iTX_DATA,
   output logic                  oTX_FULL,
   output logic                  oTX_BUSY,
   output logic                  oUART_TXD
);

   localparam int SUB_W = $clog2(TICKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 tick;
   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 full_q, full_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [SUB_W-1:0]     sub_q, sub_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 txd_q, txd_d;
   logic                 busy_q, busy_d;
   logic                 load;

   mist1032sa_uart_baudgen #(
      .BAUDRATE_FIXED   (BAUDRATE_FIXED),
      .BAUDRATE_COUNTER (BAUDRATE_COUNTER)
   ) u_baudgen (
      .iCLOCK         (iCLOCK),
      .inRESET        (inRESET),
      .iEXTBAUD_COUNT (iEXTBAUD_COUNT),
      .oTICK          (tick)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      full_d  = full_q;
      shift_d = shift_q;
      sub_d   = sub_q;
      idx_d   = idx_q;
      txd_d   = txd_q;
      load    = 1'b0;

      if (iTX_REQ && !full_q) begin
         hold_d = iTX_DATA;
         full_d = 1'b1;
      end

      if (tick) begin
         case (state_q)
            TX_IDLE: begin
               if (full_q) load = 1'b1;
            end
            TX_START: begin
               sub_d = sub_q + SUB_W'(1);
               if (sub_q == SUB_LAST) begin
                  state_d = TX_DATA;
                  idx_d   = '0;
                  txd_d   = shift_q[0];
               end
            end
            TX_DATA: begin
               sub_d = sub_q + SUB_W'(1);
               if (sub_q == SUB_LAST) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = TX_STOP;
                     txd_d   = 1'b1;
                  end else begin
                     // The bit that goes out next is shift_q[1]; it becomes
                     // the new LSB after this shift.
                     shift_d = shift_q >> 1;
                     txd_d   = shift_q[1];
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
            end
            TX_STOP: begin
               sub_d = sub_q + SUB_W'(1);
               if (sub_q == SUB_LAST) begin
                  if (full_q) load = 1'b1;
                  else        state_d = TX_IDLE;
               end
            end
            default: state_d = TX_IDLE;
         endcase
      end

      // Transfer hold -> shifter. full_q is still 1 in this cycle, so a
      // write presented in the same cycle is dropped.
      if (load) begin
         shift_d = hold_q;
         full_d  = 1'b0;
         state_d = TX_START;
         sub_d   = '0;
         txd_d   = 1'b0;
      end

      busy_d = full_d | (state_d != TX_IDLE);
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q <= TX_IDLE;
         hold_q  <= '0;
         full_q  <= 1'b0;
         shift_q <= '0;
         sub_q   <= '0;
         idx_q   <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         shift_q <= shift_d;
         sub_q   <= sub_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
      end
   end

   assign oTX_FULL  = full_q;
   assign oTX_BUSY  = busy_q;
   assign oUART_TXD = txd_q;

endmodule

// File: tb/tb_mist1032sa_uart_transmitter.sv
// Directed and randomized bench for mist1032sa_uart_transmitter.
// dut_f uses a fixed limit of 3 and dut_e uses a runtime limit, which is 3
// for most of the run. Both see the same writes and should carry the same
// line until the runtime-limit section at the end.
module tb_mist1032sa_uart_transmitter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic [7:0]  data  = 8'h00;
   logic [19:0] ext   = 20'd3;
   logic        txd_f, full_f, busy_f;
   logic        txd_e, full_e, busy_e;

   int n_chk  = 0;
   int n_pass = 0;

   mist1032sa_uart_transmitter #(
      .BAUDRATE_FIXED   (1'b1),
      .BAUDRATE_COUNTER (20'd3)
   ) dut_f (
      .iCLOCK         (clk),
      .inRESET        (rst_n),
      .iEXTBAUD_COUNT (20'd0),
      .iTX_REQ        (req),
      .iTX_DATA       (data),
      .oTX_FULL       (full_f),
      .oTX_BUSY       (busy_f),
      .oUART_TXD      (txd_f)
   );

   mist1032sa_uart_transmitter #(
      .BAUDRATE_FIXED   (1'b0),
      .BAUDRATE_COUNTER (20'd108)
   ) dut_e (
      .iCLOCK         (clk),
      .inRESET        (rst_n),
      .iEXTBAUD_COUNT (ext),
      .iTX_REQ        (req),
      .iTX_DATA       (data),
      .oTX_FULL       (full_e),
      .oTX_BUSY       (busy_e),
      .oUART_TXD      (txd_e)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      req  = 1'b1;
      data = b;
      step();
      req  = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk({tag, "_txd_f"}, txd_f, 1'b1);
         chk({tag, "_txd_e"}, txd_e, 1'b1);
         step();
      end
   endtask

   // Expected line for one byte: a 0 start bit, the data LSB first, then a
   // 1 stop bit. Each bit holds for cpb cycles. The start bit must appear
   // within max_wait cycles.
   task automatic expect_frame(input logic [7:0] b, input int max_wait, input int cpb,
                               input bit ext_only, input string tag);
      logic [9:0] bits;
      int         w;
      bit         found;
      bits = {1'b1, b, 1'b0};
      w = 0;
      while (txd_e !== 1'b0 && w < max_wait) begin
         step();
         w++;
      end
      found = (txd_e === 1'b0);
      chk({tag, "_start_seen"}, found, 1'b1);
      if (!found) return;
      chk({tag, "_full_e_at_start"}, full_e, 1'b0);
      chk({tag, "_busy_e_at_start"}, busy_e, 1'b1);
      if (!ext_only) begin
         chk({tag, "_full_f_at_start"}, full_f, 1'b0);
         chk({tag, "_busy_f_at_start"}, busy_f, 1'b1);
      end
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < cpb; c++) begin
            chk($sformatf("%s_e_bit%0d_cyc%0d", tag, k, c), txd_e, bits[k]);
            if (!ext_only) chk($sformatf("%s_f_bit%0d_cyc%0d", tag, k, c), txd_f, bits[k]);
            step();
         end
      end
   endtask

   initial begin
      logic [7:0] b1, b2, b3;
      int         w;

      // Reset state
      step(); step(); step();
      chk("rst_txd_f", txd_f, 1'b1);
      chk("rst_full_f", full_f, 1'b0);
      chk("rst_busy_f", busy_f, 1'b0);
      chk("rst_txd_e", txd_e, 1'b1);
      chk("rst_full_e", full_e, 1'b0);
      chk("rst_busy_e", busy_e, 1'b0);
      rst_n = 1'b1;
      chk_idle("idle1000", 1000);

      // Single frame 0xA5, then randomized single frames
      write_byte(8'hA5);
      chk("a5_full_after_write", full_f, 1'b1);
      expect_frame(8'hA5, 5, 16, 1'b0, "a5");
      chk("a5_busy_f_after", busy_f, 1'b0);
      chk("a5_busy_e_after", busy_e, 1'b0);
      for (int i = 0; i < 4; i++) begin
         b1 = 8'($urandom);
         write_byte(b1);
         expect_frame(b1, 5, 16, 1'b0, $sformatf("rand%0d", i));
         chk("rand_busy_f_after", busy_f, 1'b0);
         chk("rand_txd_f_after", txd_f, 1'b1);
      end
      chk_idle("gap1", 20);

      // Back-to-back 0x00 then 0xFF, second write as soon as hold empties
      write_byte(8'h00);
      fork
         begin
            expect_frame(8'h00, 5, 16, 1'b0, "b2b0");
            expect_frame(8'hFF, 0, 16, 1'b0, "b2b1");
         end
         begin
            w = 0;
            while (full_e && w < 10) begin
               step();
               w++;
            end
            chk("b2b_hold_empties", full_e, 1'b0);
            write_byte(8'hFF);
         end
      join
      chk("b2b_busy_after", busy_e, 1'b0);
      chk_idle("gap2", 20);

      // Overflow: the third write, made while hold is full, is dropped
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = ~b2;
      write_byte(b1);
      fork
         begin
            expect_frame(b1, 5, 16, 1'b0, "ovf0");
            expect_frame(b2, 0, 16, 1'b0, "ovf1");
         end
         begin
            w = 0;
            while (full_e && w < 10) begin
               step();
               w++;
            end
            write_byte(b2);
            write_byte(b3);
            chk("ovf_full_f_stays", full_f, 1'b1);
            chk("ovf_full_e_stays", full_e, 1'b1);
         end
      join
      chk("ovf_busy_after", busy_f, 1'b0);
      chk("ovf_full_after", full_f, 1'b0);
      chk_idle("ovf_no_third", 100);

      // Write held during the transfer cycle is dropped; the next one lands
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = ~b2;
      req  = 1'b1;
      data = b1;
      step();
      data = b3;
      fork
         begin
            expect_frame(b1, 5, 16, 1'b0, "xfer0");
            expect_frame(b2, 0, 16, 1'b0, "xfer1");
         end
         begin
            w = 0;
            while (full_e && w < 10) begin
               step();
               w++;
            end
            data = b2;
            step();
            req = 1'b0;
            chk("xfer_full_after_retry", full_e, 1'b1);
         end
      join
      chk_idle("gap3", 20);

      // Reset during D3 of a 0x00 frame with a byte waiting in hold
      write_byte(8'h00);
      w = 0;
      while (txd_e !== 1'b0 && w < 5) begin
         step();
         w++;
      end
      chk("mid_start_seen", txd_e, 1'b0);
      write_byte(8'hC3);
      for (int i = 0; i < 68; i++) step();
      chk("mid_pre_rst_txd", txd_f, 1'b0);
      chk("mid_pre_rst_full", full_f, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_txd_f", txd_f, 1'b1);
      chk("mid_rst_txd_e", txd_e, 1'b1);
      chk("mid_rst_full", full_f, 1'b0);
      chk("mid_rst_busy", busy_f, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      chk("mid_post_full", full_e, 1'b0);
      chk_idle("mid_hold_dropped", 50);
      write_byte(8'h5A);
      expect_frame(8'h5A, 5, 16, 1'b0, "post_rst_5a");
      chk_idle("gap4", 20);

      // Runtime limit 7: 32 clocks per bit on dut_e
      ext = 20'd7;
      step();
      b1 = 8'($urandom);
      write_byte(b1);
      expect_frame(b1, 9, 32, 1'b1, "ext7");
      chk("ext7_busy_after", busy_e, 1'b0);

      // Drop the limit to 1 while the counter sits at 5
      w = 0;
      while (dut_e.u_baudgen.cnt_q != 20'd5 && w < 20) begin
         step();
         w++;
      end
      chk("ext_cnt_reaches_5", dut_e.u_baudgen.cnt_q, 20'd5);
      ext = 20'd1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("ext1_tick%0d", i), dut_e.u_baudgen.oTICK, (i % 2 == 0) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
